// File: rtl/accum_pkt_pkg.sv
// Shared constants, FSM state type and checksum helper for the accumulated-sum packet
// transmitter.
package accum_pkt_pkg;

    localparam logic [7:0]  PKT_HDR = 8'hA5;
    localparam int unsigned SUM_W   = 20;
    localparam int unsigned SEQ_W   = 4;
    localparam int unsigned PAY_W   = SEQ_W + SUM_W;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StB2,
        StB1,
        StB0,
        StCsum
    } tx_state_e;

    // XOR of header and the three payload bytes
    function automatic logic [7:0] pkt_csum(input logic [PAY_W-1:0] payload);
        return PKT_HDR ^ payload[23:16] ^ payload[15:8] ^ payload[7:0];
    endfunction

endpackage

// File: rtl/accum_round_shift.sv
// Combinational round-half-up right shift of a window sum. The add is done one bit wider
// than the sum so the rounding increment cannot overflow; a zero shift is a pass-through.
module accum_round_shift #(
    parameter int unsigned SumW  = 20,
    parameter int unsigned Shift = 4
) (
    input  logic [SumW-1:0] sum_i,
    output logic [SumW-1:0] value_o
);

    typedef logic [SumW:0] wide_t;

    if (Shift == 0) begin : g_pass
        assign value_o = sum_i;
    end else begin : g_round
        localparam wide_t Rnd = wide_t'(1) << (Shift - 1);

        wide_t wide;

        // Add half an LSB of the result, then drop the fractional bits
        assign wide    = {1'b0, sum_i} + Rnd;
        assign value_o = SumW'(wide >> Shift);
    end

endmodule

// File: rtl/accum_packet_tx.sv
// Serialises completed accumulation-window sums as 5-byte packets
// (A5, P[23:16], P[15:8], P[7:0], checksum) with P = {seq, value} onto a valid/ready byte
// stream. A shadow register holds the packet in flight and a one-deep pending register
// absorbs one more window; further windows are dropped and counted.
// Build option: define ACCUM_PACKET_TX_AVG_EN to send the rounded average
// (sum >> AVG_SHIFT) instead of the raw sum.
module accum_packet_tx
    import accum_pkt_pkg::*;
#(
    parameter int unsigned AVG_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SUM_W-1:0] sum_in_i,
    input  logic             sum_stb_i,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic             busy_o,
    output logic             overflow_o,
    output logic [7:0]       drop_cnt_o,
    input  logic             clr_ovf_i
);

    tx_state_e        state_q, state_d;
    logic [SUM_W-1:0] shadow_q, shadow_d;
    logic [SUM_W-1:0] pending_q, pending_d;
    logic             pending_full_q, pending_full_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q, busy_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic [SUM_W-1:0] cap_value;
    logic             accept;
    logic             csum_accept;
    logic             drop;

`ifdef ACCUM_PACKET_TX_AVG_EN
    accum_round_shift #(
        .SumW  (SUM_W),
        .Shift (AVG_SHIFT)
    ) u_round_shift (
        .sum_i   (sum_in_i),
        .value_o (cap_value)
    );
`else
    assign cap_value = sum_in_i;
`endif

    assign accept      = tx_valid_q && tx_ready_i;
    assign csum_accept = accept && (state_q == StCsum);

    // A window is lost only when both slots are occupied and the checksum handover does
    // not free the pending slot in the same cycle
    assign drop = sum_stb_i && (state_q != StIdle) && pending_full_q && !csum_accept;

    // Next-state: packet sequencing, sum capture and drop accounting
    always_comb begin
        state_d        = state_q;
        shadow_d       = shadow_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        seq_d          = seq_q;
        tx_data_d      = tx_data_q;
        tx_valid_d     = tx_valid_q;

        if (state_q == StIdle) begin
            if (pending_full_q) begin
                // Older pending sum goes first; a new strobe refills the slot
                shadow_d = pending_q;
                if (sum_stb_i) begin
                    pending_d = cap_value;
                end else begin
                    pending_full_d = 1'b0;
                end
                state_d    = StHdr;
                tx_valid_d = 1'b1;
                tx_data_d  = PKT_HDR;
            end else if (sum_stb_i) begin
                shadow_d   = cap_value;
                state_d    = StHdr;
                tx_valid_d = 1'b1;
                tx_data_d  = PKT_HDR;
            end
        end else begin
            if (sum_stb_i && !pending_full_q) begin
                pending_d      = cap_value;
                pending_full_d = 1'b1;
            end
            if (accept) begin
                case (state_q)
                    StHdr: begin
                        state_d   = StB2;
                        tx_data_d = {seq_q, shadow_q[19:16]};
                    end
                    StB2: begin
                        state_d   = StB1;
                        tx_data_d = shadow_q[15:8];
                    end
                    StB1: begin
                        state_d   = StB0;
                        tx_data_d = shadow_q[7:0];
                    end
                    StB0: begin
                        state_d   = StCsum;
                        tx_data_d = pkt_csum({seq_q, shadow_q});
                    end
                    StCsum: begin
                        seq_d = seq_q + SEQ_W'(1);
                        if (pending_full_q) begin
                            shadow_d       = pending_q;
                            pending_full_d = sum_stb_i;
                            if (sum_stb_i) begin
                                pending_d = cap_value;
                            end
                            state_d   = StHdr;
                            tx_data_d = PKT_HDR;
                        end else begin
                            state_d    = StIdle;
                            tx_valid_d = 1'b0;
                            tx_data_d  = 8'h00;
                        end
                    end
                    default: begin
                        state_d    = StIdle;
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                    end
                endcase
            end
        end

        busy_d = (state_d != StIdle) || pending_full_d;

        // A drop in the same cycle as a clear leaves exactly one recorded drop
        overflow_d = clr_ovf_i ? 1'b0 : overflow_q;
        drop_cnt_d = clr_ovf_i ? 8'h00 : drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_d != 8'hFF) begin
                drop_cnt_d = drop_cnt_d + 8'd1;
            end
        end
    end

    // State and registered outputs; synchronous active-low reset aborts any packet
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StIdle;
            shadow_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            seq_q          <= '0;
            tx_data_q      <= 8'h00;
            tx_valid_q     <= 1'b0;
            busy_q         <= 1'b0;
            overflow_q     <= 1'b0;
            drop_cnt_q     <= 8'h00;
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            seq_q          <= seq_d;
            tx_data_q      <= tx_data_d;
            tx_valid_q     <= tx_valid_d;
            busy_q         <= busy_d;
            overflow_q     <= overflow_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign busy_o     = busy_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule
